// File: rtl/suite_pkg.sv
// Shared definitions for the test-suite input controller: joystick bit map,
// repeat-state encoding and the wrapping step helpers used on the pending settings.
package suite_pkg;

  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_A    = 4;
  localparam int JOY_B    = 5;
  localparam int JOY_BITS = 6;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_t;

  // Wrapping is done with explicit compares so non-power-of-two ranges behave.
  function automatic logic [3:0] levelUp(input logic [3:0] lvl, input logic [3:0] maxLvl);
    levelUp = (lvl >= maxLvl) ? 4'd0 : lvl + 4'd1;
  endfunction

  function automatic logic [3:0] levelDown(input logic [3:0] lvl, input logic [3:0] maxLvl);
    levelDown = (lvl == 4'd0) ? maxLvl : lvl - 4'd1;
  endfunction

  function automatic logic [2:0] patUp(input logic [2:0] pat, input logic [2:0] maxPat);
    patUp = (pat >= maxPat) ? 3'd0 : pat + 3'd1;
  endfunction

  function automatic logic [2:0] patDown(input logic [2:0] pat, input logic [2:0] maxPat);
    patDown = (pat == 3'd0) ? maxPat : pat - 3'd1;
  endfunction

endpackage

// File: rtl/suite_input_ctrl_if.sv
// Bundle between the joystick/OSD/timing sources and the suite renderer configuration.
interface suite_input_ctrl_if;

  logic [31:0] joy;
  logic        osd_active;
  logic        v_blank;
  logic [3:0]  layer_1_level;
  logic [2:0]  pattern_sel;
  logic        cfg_update;

  modport master (
    output joy,
    output osd_active,
    output v_blank,
    input  layer_1_level,
    input  pattern_sel,
    input  cfg_update
  );

  modport slave (
    input  joy,
    input  osd_active,
    input  v_blank,
    output layer_1_level,
    output pattern_sel,
    output cfg_update
  );

endinterface

// File: rtl/btn_debounce.sv
// One joystick bit: 2-flop synchronizer, stability counter and a 1-cycle press pulse
// on the released-to-pressed transition of the debounced state.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_state,
  output logic o_press
);

  logic        r_sync1;
  logic        r_sync2;
  logic [19:0] r_cnt;
  logic        r_state;
  logic        r_press;

  // The counter only runs while the synchronized level disagrees with the debounced state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= 20'd0;
      r_state <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_state) begin
        r_cnt <= 20'd0;
      end else if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
        r_cnt   <= 20'd0;
        r_state <= ~r_state;
        r_press <= ~r_state;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

  assign o_state = r_state;
  assign o_press = r_press;

endmodule

// File: rtl/suite_input_ctrl.sv
// Joystick-driven configuration for the suite renderer: debounced events and A/B
// auto-repeat edit pending settings, which are committed on each vertical-blank rise.
module suite_input_ctrl
  import suite_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000,
  parameter logic [5:0]  REPEAT_DELAY    = 6'd30,
  parameter logic [5:0]  REPEAT_RATE     = 6'd6,
  parameter logic [3:0]  LEVEL_MAX       = 4'd10,
  parameter int          NUM_PATTERNS    = 8
) (
  input  logic          clk,
  input  logic          reset,
  suite_input_ctrl_if.slave bus
);

  localparam logic [2:0] PAT_MAX = 3'(NUM_PATTERNS - 1);

  logic [JOY_BITS-1:0] w_held;
  logic [JOY_BITS-1:0] w_press;

  for (genvar gi = 0; gi < JOY_BITS; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (bus.joy[gi]),
      .o_state(w_held[gi]),
      .o_press(w_press[gi])
    );
  end

  logic w_unusedBits;
  assign w_unusedBits = ^{bus.joy[31:JOY_BITS], w_press[JOY_D], w_held[JOY_U:JOY_R]};

  logic r_vbDly;
  logic w_tick;
  assign w_tick = bus.v_blank & ~r_vbDly;

  rpt_state_t r_rptState;
  rpt_state_t w_rptStateNext;
  logic [5:0] r_rptCnt;
  logic [5:0] w_rptCntNext;
  logic       r_rptKeyB;
  logic       w_rptKeyBNext;
  logic       w_rptEvt;
  logic       w_abort;

  // The held key is remembered so a hand-over from A to B is treated as a release.
  assign w_abort = bus.osd_active
                 | ~(w_held[JOY_A] ^ w_held[JOY_B])
                 | (w_held[JOY_B] != r_rptKeyB);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vbDly    <= 1'b0;
      r_rptState <= IDLE;
      r_rptCnt   <= 6'd0;
      r_rptKeyB  <= 1'b0;
    end else begin
      r_vbDly    <= bus.v_blank;
      r_rptState <= w_rptStateNext;
      r_rptCnt   <= w_rptCntNext;
      r_rptKeyB  <= w_rptKeyBNext;
    end
  end

  always_comb begin
    w_rptStateNext = r_rptState;
    w_rptCntNext   = r_rptCnt;
    w_rptKeyBNext  = r_rptKeyB;
    w_rptEvt       = 1'b0;
    unique case (r_rptState)
      IDLE: begin
        if (!bus.osd_active && (w_press[JOY_A] || w_press[JOY_B])
            && (w_held[JOY_A] ^ w_held[JOY_B])) begin
          w_rptStateNext = HOLD;
          w_rptCntNext   = 6'd0;
          w_rptKeyBNext  = w_held[JOY_B];
        end
      end
      HOLD: begin
        if (w_abort) begin
          w_rptStateNext = IDLE;
          w_rptCntNext   = 6'd0;
        end else if (w_tick) begin
          if (r_rptCnt + 6'd1 == REPEAT_DELAY) begin
            w_rptEvt       = 1'b1;
            w_rptStateNext = REPEAT;
            w_rptCntNext   = 6'd0;
          end else begin
            w_rptCntNext = r_rptCnt + 6'd1;
          end
        end
      end
      REPEAT: begin
        if (w_abort) begin
          w_rptStateNext = IDLE;
          w_rptCntNext   = 6'd0;
        end else if (w_tick) begin
          if (r_rptCnt + 6'd1 == REPEAT_RATE) begin
            w_rptEvt     = 1'b1;
            w_rptCntNext = 6'd0;
          end else begin
            w_rptCntNext = r_rptCnt + 6'd1;
          end
        end
      end
      default: begin
        w_rptStateNext = IDLE;
        w_rptCntNext   = 6'd0;
      end
    endcase
  end

  logic w_evA;
  logic w_evB;
  logic w_evR;
  logic w_evL;
  logic w_evU;

  assign w_evA = ~bus.osd_active & (w_press[JOY_A] | (w_rptEvt & ~r_rptKeyB));
  assign w_evB = ~bus.osd_active & (w_press[JOY_B] | (w_rptEvt &  r_rptKeyB));
  assign w_evR = ~bus.osd_active & w_press[JOY_R];
  assign w_evL = ~bus.osd_active & w_press[JOY_L];
  assign w_evU = ~bus.osd_active & w_press[JOY_U];

  logic [3:0] r_pendLevel;
  logic [2:0] r_pendPat;

  // U wins outright; opposing keys in the same cycle cancel each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pendLevel <= LEVEL_MAX;
      r_pendPat   <= 3'd0;
    end else if (w_evU) begin
      r_pendLevel <= LEVEL_MAX;
      r_pendPat   <= 3'd0;
    end else begin
      if (w_evA && !w_evB) begin
        r_pendLevel <= levelUp(r_pendLevel, LEVEL_MAX);
      end else if (w_evB && !w_evA) begin
        r_pendLevel <= levelDown(r_pendLevel, LEVEL_MAX);
      end
      if (w_evR && !w_evL) begin
        r_pendPat <= patUp(r_pendPat, PAT_MAX);
      end else if (w_evL && !w_evR) begin
        r_pendPat <= patDown(r_pendPat, PAT_MAX);
      end
    end
  end

  logic [3:0] r_level;
  logic [2:0] r_pattern;
  logic       r_cfgUpdate;

  // Commit samples the pending values from before any same-cycle event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level     <= LEVEL_MAX;
      r_pattern   <= 3'd0;
      r_cfgUpdate <= 1'b0;
    end else begin
      r_cfgUpdate <= 1'b0;
      if (w_tick) begin
        r_level     <= r_pendLevel;
        r_pattern   <= r_pendPat;
        r_cfgUpdate <= (r_pendLevel != r_level) || (r_pendPat != r_pattern);
      end
    end
  end

  assign bus.layer_1_level = r_level;
  assign bus.pattern_sel   = r_pattern;
  assign bus.cfg_update    = r_cfgUpdate;

endmodule
